// File: rtl/v8cpu_pkg.sv
// Shared v8cpu constants, ALU opcode values and the issue-stage payload.
package v8cpu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;

  // Operand bundle held in the issue register and presented to the ALU.
  typedef struct packed {
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [ALU_OP_W-1:0] op;
    logic [DATA_W-1:0]   flags;
  } alu_req_t;

endpackage

// File: rtl/v8cpu_rr_arbiter.sv
// Round-robin pick: first asserted request at or after i_ptr, wrapping.
// Ports: i_req (request vector), i_ptr (priority start index),
//        o_grant_c (one-hot winner), o_idx_c (winner index), o_any_c (any request).
module v8cpu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [ID_W-1:0]    o_idx_c,
  output logic               o_any_c
);

  logic [ID_W-1:0] w_cand;

  // Scan from the pointer; the first hit wins.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = ID_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_any_c && i_req[w_cand]) begin
        o_any_c = 1'b1;
        o_idx_c = w_cand;
      end
    end
    if (o_any_c) o_grant_c[o_idx_c] = 1'b1;
  end

endmodule

// File: rtl/v8cpu_alu_arbiter.sv
// Shares one combinational v8cpu_alu between NUM_REQ requesters.
// Ports: req_valid/req_ready + packed req_a/req_b/req_op/req_flags per requester;
//        alu_a/alu_b/alu_op/alu_flags to the ALU, alu_c/alu_newflags back;
//        rsp_valid/rsp_ready handshake with rsp_id/rsp_c/rsp_flags payload.
module v8cpu_alu_arbiter
  import v8cpu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]    req_a,
  input  logic [NUM_REQ*DATA_W-1:0]    req_b,
  input  logic [NUM_REQ*ALU_OP_W-1:0]  req_op,
  input  logic [NUM_REQ*DATA_W-1:0]    req_flags,
  output logic [DATA_W-1:0]            alu_a,
  output logic [DATA_W-1:0]            alu_b,
  output logic [ALU_OP_W-1:0]          alu_op,
  output logic [DATA_W-1:0]            alu_flags,
  input  logic [DATA_W-1:0]            alu_c,
  input  logic [DATA_W-1:0]            alu_newflags,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATA_W-1:0]            rsp_c,
  output logic [DATA_W-1:0]            rsp_flags
);

  alu_req_t            r_iss;
  logic                r_iss_valid;
  logic [ID_W-1:0]     r_iss_id;
  logic [ID_W-1:0]     r_rr_ptr;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_c;
  logic [DATA_W-1:0]   r_rsp_flags;

  logic                w_rsp_free;
  logic                w_iss_adv;
  logic                w_iss_free;
  logic                w_any;
  logic                w_accept;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_win_idx;
  logic [ID_W-1:0]     w_ptr_nxt;
  alu_req_t            w_sel;

  v8cpu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_win_idx),
    .o_any_c   (w_any)
  );

  // Pipeline occupancy: the issue slot frees when it moves into the response slot.
  assign w_rsp_free = !r_rsp_valid || rsp_ready;
  assign w_iss_adv  = r_iss_valid && w_rsp_free;
  assign w_iss_free = !r_iss_valid || w_iss_adv;
  assign w_accept   = w_any && w_iss_free;

  // Held low through reset even though the idle pipeline would otherwise accept.
  assign req_ready = (rst_n && w_accept) ? w_grant : '0;

  assign w_ptr_nxt = (w_win_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_win_idx + ID_W'(1);

  // Operand mux for the winning requester.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_win_idx == ID_W'(i)) begin
        w_sel.a     = req_a[i*DATA_W +: DATA_W];
        w_sel.b     = req_b[i*DATA_W +: DATA_W];
        w_sel.op    = req_op[i*ALU_OP_W +: ALU_OP_W];
        w_sel.flags = req_flags[i*DATA_W +: DATA_W];
      end
    end
  end

  // Issue stage; operands are kept after advance so the ALU inputs stay steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss       <= '0;
      r_iss_valid <= 1'b0;
      r_iss_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_iss       <= w_sel;
      r_iss_valid <= 1'b1;
      r_iss_id    <= w_win_idx;
      r_rr_ptr    <= w_ptr_nxt;
    end else if (w_iss_adv) begin
      r_iss_valid <= 1'b0;
    end
  end

  // Response stage captures the ALU result as the issue slot advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_c     <= '0;
      r_rsp_flags <= '0;
    end else if (w_iss_adv) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_iss_id;
      r_rsp_c     <= alu_c;
      r_rsp_flags <= alu_newflags;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign alu_a     = r_iss.a;
  assign alu_b     = r_iss.b;
  assign alu_op    = r_iss.op;
  assign alu_flags = r_iss.flags;

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_c     = r_rsp_c;
  assign rsp_flags = r_rsp_flags;

endmodule
